// File: rtl/fact_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fact_arbiter
// Purpose  : Round-robin arbiter sharing one factorial unit among NREQ
//            requesters, with operand range check and WAIT watchdog.
// Revision : 1.0
// ============================================================================
module fact_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   n_in,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     resp_valid,
  output logic [WIDTH-1:0]    result,
  output logic                err,
  output logic                busy,
  output logic [3:0]          fu_n,
  output logic                fu_go,
  input  logic                fu_done,
  input  logic                fu_err,
  input  logic [WIDTH-1:0]    fu_result
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam int C_MAX_N = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [3:0]       n_reg_q, n_reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [3:0]       pick_n;
  logic             n_ok;

  // Two passes: requesters at/after the pointer first, then wrap to the rest.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_n   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!pick_vld && req[j] && (PW'(j) >= ptr_q)) begin
        pick_vld = 1'b1;
        pick_idx = PW'(j);
        pick_n   = n_in[4*j +: 4];
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(j);
        pick_n   = n_in[4*j +: 4];
      end
    end
  end

  assign n_ok = (n_reg_q <= 4'(C_MAX_N));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    n_reg_d  = n_reg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          n_reg_d = pick_n;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (n_ok) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      WAIT: begin
        // Unit error wins over a simultaneous done; done wins over the watchdog.
        if (fu_err) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else if (fu_done) begin
          result_d = fu_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      n_reg_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      n_reg_q  <= n_reg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    gnt        = '0;
    resp_valid = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt[j]        = (state_q == ISSUE) && (owner_q == PW'(j));
      resp_valid[j] = (state_q == RESP)  && (owner_q == PW'(j));
    end
  end

  assign fu_go  = (state_q == ISSUE) && n_ok;
  assign fu_n   = ((state_q == ISSUE) || (state_q == WAIT)) ? n_reg_q : 4'd0;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fact_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fact_arbiter
// Purpose  : Self-checking bench for fact_arbiter: directed vector table,
//            reset-in-WAIT sequence and randomized jobs against a model.
// Revision : 1.0
// ============================================================================
module tb_fact_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 12;

  localparam int M_DONE = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] n_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   resp_valid;
  logic [WIDTH-1:0]  result;
  logic              err;
  logic              busy;
  logic [3:0]        fu_n;
  logic              fu_go;
  logic              fu_done;
  logic              fu_err;
  logic [WIDTH-1:0]  fu_result;

  fact_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .n_in       (n_in),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .fu_n       (fu_n),
    .fu_go      (fu_go),
    .fu_done    (fu_done),
    .fu_err     (fu_err),
    .fu_result  (fu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int ptr_m;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] ni;
    int          mode;
    int          d;
    logic [3:0]  eg;
    logic        go;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fact(input int n);
    logic [31:0] f;
    f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * 32'(i);
    return f;
  endfunction

  // Round-robin reference: first set bit at or after the pointer, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic run_job(input logic [3:0] r, input logic [15:0] ni, input int mode,
                         input int d, input logic [3:0] eg, input logic eg_go,
                         input logic [31:0] er, input logic ee, input string tag);
    int k;
    int own;
    int exp_k;
    bit got;
    logic [3:0] n;
    own = 0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) own = i;
    n = ni[own*4 +: 4];
    @(negedge clk);
    req  = r;
    n_in = ni;
    got  = 0;
    for (k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        got = 1;
        break;
      end
    end
    chk({tag, " gnt_latency"}, 64'(k), 64'd1);
    if (!got) begin
      req = '0;
      return;
    end
    req = '0;
    chk({tag, " gnt"}, 64'(gnt), 64'(eg));
    chk({tag, " fu_go"}, 64'(fu_go), 64'(eg_go));
    if (eg_go) chk({tag, " fu_n_issue"}, 64'(fu_n), 64'(n));
    exp_k = !eg_go ? 1 : (mode == M_NONE ? TIMEOUT + 1 : d + 2);
    got = 0;
    for (k = 1; k <= TIMEOUT + 4; k++) begin
      @(negedge clk);
      fu_done = 1'b0;
      fu_err  = 1'b0;
      if (resp_valid != '0) begin
        got = 1;
        break;
      end
      if (k == 1) chk({tag, " fu_n_wait"}, 64'(fu_n), 64'(n));
      if (mode != M_NONE && k == d + 1) begin
        fu_done   = (mode != M_ERR);
        fu_err    = (mode != M_DONE);
        fu_result = (mode == M_ERR) ? 32'hDEADBEEF : fact(int'(fu_n));
      end
    end
    chk({tag, " resp_latency"}, 64'(k), 64'(exp_k));
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'(eg));
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " err"}, 64'(err), 64'(ee));
    @(negedge clk);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    chk({tag, " idle_result_hold"}, 64'({err, result}), 64'({ee, er}));
    chk({tag, " idle_resp"}, 64'(resp_valid), 64'd0);
    if (mode == M_NONE) begin
      fu_done   = 1'b1;
      fu_result = 32'h1234;
      @(negedge clk);
      fu_done = 1'b0;
      chk({tag, " stray_done_resp"}, 64'(resp_valid), 64'd0);
      chk({tag, " stray_done_busy"}, 64'(busy), 64'd0);
    end
    ptr_m = (own + 1) % NREQ;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ptr_m     = 0;
    reset     = 1'b1;
    req       = '0;
    n_in      = '0;
    fu_done   = 1'b0;
    fu_err    = 1'b0;
    fu_result = '0;

    tbl[0]  = '{4'b1111, 16'h3333, M_DONE, 1, 4'b0001, 1'b1, 32'd6, 1'b0};
    tbl[1]  = '{4'b1111, 16'h3333, M_DONE, 0, 4'b0010, 1'b1, 32'd6, 1'b0};
    tbl[2]  = '{4'b1111, 16'h3333, M_DONE, 3, 4'b0100, 1'b1, 32'd6, 1'b0};
    tbl[3]  = '{4'b1111, 16'h3333, M_DONE, 0, 4'b1000, 1'b1, 32'd6, 1'b0};
    tbl[4]  = '{4'b1111, 16'h3333, M_DONE, 2, 4'b0001, 1'b1, 32'd6, 1'b0};
    tbl[5]  = '{4'b0001, 16'h0005, M_DONE, 2, 4'b0001, 1'b1, 32'd120, 1'b0};
    tbl[6]  = '{4'b0100, 16'h0D00, M_DONE, 0, 4'b0100, 1'b0, 32'd0, 1'b1};
    tbl[7]  = '{4'b0010, 16'h00C0, M_DONE, 4, 4'b0010, 1'b1, 32'd479001600, 1'b0};
    tbl[8]  = '{4'b1000, 16'h7000, M_BOTH, 1, 4'b1000, 1'b1, 32'd0, 1'b1};
    tbl[9]  = '{4'b0001, 16'h0000, M_ERR,  0, 4'b0001, 1'b1, 32'd0, 1'b1};
    tbl[10] = '{4'b0010, 16'h0040, M_NONE, 0, 4'b0010, 1'b1, 32'd0, 1'b1};
    tbl[11] = '{4'b0011, 16'h0021, M_DONE, 0, 4'b0001, 1'b1, 32'd1, 1'b0};
    tbl[12] = '{4'b0011, 16'h0021, M_DONE, 1, 4'b0010, 1'b1, 32'd2, 1'b0};
    tbl[13] = '{4'b0101, 16'h0000, M_DONE, 0, 4'b0100, 1'b1, 32'd1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({gnt, resp_valid, fu_go, busy, err, fu_n, result}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 64'({gnt, resp_valid, fu_go, busy}), 64'd0);

    for (int v = 0; v < 14; v++) begin
      run_job(tbl[v].r, tbl[v].ni, tbl[v].mode, tbl[v].d, tbl[v].eg, tbl[v].go,
              tbl[v].er, tbl[v].ee, $sformatf("vec%0d", v));
    end

    // Reset while a job is in WAIT: job is dropped and the pointer returns to 0.
    @(negedge clk);
    req  = 4'b0100;
    n_in = 16'h0300;
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (gnt != '0) begin
          got = 1;
          break;
        end
      end
      chk("rstwait gnt", 64'(gnt), 64'b0100);
    end
    req = '0;
    repeat (2) @(negedge clk);
    chk("rstwait in_wait_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rstwait outputs", 64'({gnt, resp_valid, fu_go, busy, err, fu_n, result}), 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    fu_done   = 1'b1;
    fu_result = 32'd6;
    @(negedge clk);
    fu_done = 1'b0;
    chk("rstwait stray_resp", 64'(resp_valid), 64'd0);
    chk("rstwait stray_busy", 64'(busy), 64'd0);
    ptr_m = 0;
    run_job(4'b1111, 16'h5555, M_DONE, 1, 4'b0001, 1'b1, 32'd120, 1'b0, "rstwait next");

    for (int it = 0; it < 40; it++) begin
      logic [3:0]  r;
      logic [15:0] ni;
      logic [3:0]  n;
      logic        go;
      int          mode;
      int          d;
      int          own;
      r    = 4'($urandom_range(1, 15));
      ni   = 16'($urandom);
      mode = int'($urandom_range(0, 3));
      d    = int'($urandom_range(0, TIMEOUT - 2));
      own  = pick(r, ptr_m);
      n    = ni[own*4 +: 4];
      go   = (n <= 4'd12);
      run_job(r, ni, mode, d, 4'(1 << own), go,
              (go && mode == M_DONE) ? fact(int'(n)) : 32'd0,
              !(go && mode == M_DONE), $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
